// File: rtl/crossbar_arbiter.sv
// rtl/crossbar_arbiter.sv - N-requester to M-output locking crossbar arbiter with permission table
module crossbar_arbiter #(
    parameter int N  = 4,
    parameter int M  = 4,
    parameter int DW = $clog2(M),
    parameter int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] dest,
    input  logic [N-1:0]    last,
    output logic [N-1:0]    grant,
    output logic [M*SW-1:0] sel,
    output logic [M-1:0]    out_busy,
    output logic [N-1:0]    deny,
    input  logic            cfg_we,
    input  logic [SW-1:0]   cfg_src,
    input  logic [M-1:0]    cfg_mask
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state_q [M];
    state_t        state_d [M];
    logic [SW-1:0] owner_q [M];
    logic [SW-1:0] owner_d [M];
    logic [SW-1:0] ptr_q   [M];
    logic [SW-1:0] ptr_d   [M];
    logic [M-1:0]  perm_q  [N];
    logic [M-1:0]  dest_oh [N];
    logic [N-1:0]  deny_d;
    logic [N-1:0]  deny_q;

    // One-hot decode of each destination; an out-of-range index decodes to all zeros
    always_comb begin
        for (int i = 0; i < N; i++) begin
            dest_oh[i] = '0;
            for (int j = 0; j < M; j++) begin
                if (dest[i*DW +: DW] == DW'(j)) begin
                    dest_oh[i][j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            deny_d[i] = req[i] & ~|(dest_oh[i] & perm_q[i]);
        end
    end

    always_comb begin
        grant    = '0;
        out_busy = '0;
        sel      = '0;
        for (int j = 0; j < M; j++) begin
            if (state_q[j] == BUSY) begin
                out_busy[j]      = 1'b1;
                sel[j*SW +: SW]  = owner_q[j];
                for (int i = 0; i < N; i++) begin
                    if (owner_q[j] == SW'(i)) begin
                        grant[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < M; j++) begin
            logic found;
            logic own_req;
            logic own_last;
            int   idx;
            state_d[j] = state_q[j];
            owner_d[j] = owner_q[j];
            ptr_d[j]   = ptr_q[j];
            found      = 1'b0;
            own_req    = 1'b0;
            own_last   = 1'b0;
            idx        = 0;
            case (state_q[j])
                IDLE: begin
                    // Round-robin scan starting just past the last releasing owner
                    for (int k = 1; k <= N; k++) begin
                        idx = (int'(ptr_q[j]) + k) % N;
                        if (!found && req[idx] && dest_oh[idx][j] && perm_q[idx][j] && !grant[idx]) begin
                            found      = 1'b1;
                            owner_d[j] = SW'(idx);
                        end
                    end
                    if (found) begin
                        state_d[j] = BUSY;
                    end
                end
                BUSY: begin
                    for (int i = 0; i < N; i++) begin
                        if (owner_q[j] == SW'(i)) begin
                            own_req  = req[i];
                            own_last = last[i];
                        end
                    end
                    // A dropped request (abort) releases exactly like a last beat
                    if (!own_req || own_last) begin
                        state_d[j] = IDLE;
                        ptr_d[j]   = owner_q[j];
                    end
                end
                default: state_d[j] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < M; j++) begin
                state_q[j] <= IDLE;
                owner_q[j] <= '0;
                ptr_q[j]   <= SW'(N - 1);
            end
            for (int i = 0; i < N; i++) begin
                perm_q[i] <= '1;
            end
            deny_q <= '0;
        end else begin
            for (int j = 0; j < M; j++) begin
                state_q[j] <= state_d[j];
                owner_q[j] <= owner_d[j];
                ptr_q[j]   <= ptr_d[j];
            end
            if (cfg_we && (int'(cfg_src) < N)) begin
                perm_q[cfg_src] <= cfg_mask;
            end
            deny_q <= deny_d;
        end
    end

    assign deny = deny_q;

endmodule
